// File: rtl/rtc_bcd_counter.sv
// Real-time clock kept as packed BCD digits, with a one-second prescaler,
// 12/24-hour modes, a validated time load, a day-rollover pulse and a load-error pulse.
module rtc_bcd_counter #(
   parameter bit          MODE24 = 1'b1,
   parameter int unsigned DIV    = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [19:0] ld_time,
   input  logic        ld_pm,
   output logic [1:0]  hh_t,
   output logic [3:0]  hh_o,
   output logic [2:0]  mm_t,
   output logic [3:0]  mm_o,
   output logic [2:0]  ss_t,
   output logic [3:0]  ss_o,
   output logic        pm,
   output logic        day_pulse,
   output logic        ld_err
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   // Midnight is 00:00:00 in 24-hour mode and 12:00:00 (AM) in 12-hour mode
   localparam logic [1:0] HT_RST = MODE24 ? 2'd0 : 2'd1;
   localparam logic [3:0] HO_RST = MODE24 ? 4'd0 : 4'd2;

   logic [PW-1:0] presc, presc_n;
   logic [1:0]    hh_t_n;
   logic [3:0]    hh_o_n;
   logic [2:0]    mm_t_n;
   logic [3:0]    mm_o_n;
   logic [2:0]    ss_t_n;
   logic [3:0]    ss_o_n;
   logic          pm_n;
   logic          day_n;
   logic          err_n;

   logic          sec_tick_c;
   logic          sec_wrap_c;
   logic          min_wrap_c;
   logic          ld_ok_c;

   logic [1:0]    l_ht;
   logic [3:0]    l_ho;
   logic [2:0]    l_mt;
   logic [3:0]    l_mo;
   logic [2:0]    l_st;
   logic [3:0]    l_so;

   assign {l_ht, l_ho, l_mt, l_mo, l_st, l_so} = ld_time;

   assign sec_tick_c = en && (presc == PMAX);
   assign sec_wrap_c = (ss_t == 3'd5) && (ss_o == 4'd9);
   assign min_wrap_c = (mm_t == 3'd5) && (mm_o == 4'd9);

   // Load legality: BCD ones digits, 00..59 for min/sec, mode-dependent hour range
   always_comb begin
      ld_ok_c = (l_ho <= 4'd9) && (l_mo <= 4'd9) && (l_so <= 4'd9) &&
                (l_mt <= 3'd5) && (l_st <= 3'd5);
      if (MODE24) begin
         ld_ok_c = ld_ok_c && ((l_ht < 2'd2) || ((l_ht == 2'd2) && (l_ho <= 4'd3)));
      end else begin
         ld_ok_c = ld_ok_c && (((l_ht == 2'd0) && (l_ho != 4'd0)) ||
                               ((l_ht == 2'd1) && (l_ho <= 4'd2)));
      end
   end

   // Next-state: prescaler, one-second increment with full carry chain, then load override
   always_comb begin
      presc_n = presc;
      hh_t_n  = hh_t;
      hh_o_n  = hh_o;
      mm_t_n  = mm_t;
      mm_o_n  = mm_o;
      ss_t_n  = ss_t;
      ss_o_n  = ss_o;
      pm_n    = pm;
      day_n   = 1'b0;
      err_n   = 1'b0;

      if (en) begin
         presc_n = sec_tick_c ? '0 : presc + PW'(1);
      end

      if (sec_tick_c) begin
         if (ss_o == 4'd9) begin
            ss_o_n = 4'd0;
            ss_t_n = (ss_t == 3'd5) ? 3'd0 : ss_t + 3'd1;
         end else begin
            ss_o_n = ss_o + 4'd1;
         end

         if (sec_wrap_c) begin
            if (mm_o == 4'd9) begin
               mm_o_n = 4'd0;
               mm_t_n = (mm_t == 3'd5) ? 3'd0 : mm_t + 3'd1;
            end else begin
               mm_o_n = mm_o + 4'd1;
            end

            if (min_wrap_c) begin
               if (MODE24) begin
                  if ((hh_t == 2'd2) && (hh_o == 4'd3)) begin
                     hh_t_n = 2'd0;
                     hh_o_n = 4'd0;
                     day_n  = 1'b1;
                  end else if (hh_o == 4'd9) begin
                     hh_t_n = hh_t + 2'd1;
                     hh_o_n = 4'd0;
                  end else begin
                     hh_o_n = hh_o + 4'd1;
                  end
               end else begin
                  if ((hh_t == 2'd1) && (hh_o == 4'd2)) begin
                     hh_t_n = 2'd0;
                     hh_o_n = 4'd1;
                  end else if ((hh_t == 2'd1) && (hh_o == 4'd1)) begin
                     // 11 -> 12 flips the meridiem; PM->AM is midnight
                     hh_o_n = 4'd2;
                     pm_n   = ~pm;
                     day_n  = pm;
                  end else if (hh_o == 4'd9) begin
                     hh_t_n = 2'd1;
                     hh_o_n = 4'd0;
                  end else begin
                     hh_o_n = hh_o + 4'd1;
                  end
               end
            end
         end
      end

      if (load) begin
         if (ld_ok_c) begin
            {hh_t_n, hh_o_n, mm_t_n, mm_o_n, ss_t_n, ss_o_n} = ld_time;
            pm_n    = ld_pm;
            presc_n = '0;
            day_n   = 1'b0;
         end else begin
            err_n = 1'b1;
         end
      end

      // In 24-hour mode pm is purely a function of the resulting hour
      if (MODE24) begin
         pm_n = (hh_t_n == 2'd2) || ((hh_t_n == 2'd1) && (hh_o_n >= 4'd2));
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         hh_t      <= HT_RST;
         hh_o      <= HO_RST;
         mm_t      <= 3'd0;
         mm_o      <= 4'd0;
         ss_t      <= 3'd0;
         ss_o      <= 4'd0;
         pm        <= 1'b0;
         day_pulse <= 1'b0;
         ld_err    <= 1'b0;
      end else begin
         presc     <= presc_n;
         hh_t      <= hh_t_n;
         hh_o      <= hh_o_n;
         mm_t      <= mm_t_n;
         mm_o      <= mm_o_n;
         ss_t      <= ss_t_n;
         ss_o      <= ss_o_n;
         pm        <= pm_n;
         day_pulse <= day_n;
         ld_err    <= err_n;
      end
   end

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Bench for rtc_bcd_counter: one 12-hour and one 24-hour instance (DIV=4) driven
// in lockstep, compared every cycle to a seconds-of-day reference model.
module tb_rtc_bcd_counter;

   localparam int DIVT = 4;
   localparam int DAY  = 86400;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [19:0] ld_time = 20'd0;
   logic        ld_pm = 1'b0;

   logic [1:0]  h_t[2];
   logic [3:0]  h_o[2];
   logic [2:0]  m_t[2];
   logic [3:0]  m_o[2];
   logic [2:0]  s_t[2];
   logic [3:0]  s_o[2];
   logic        pmo[2];
   logic        dpo[2];
   logic        ero[2];

   int total = 0;
   int bad = 0;

   // Reference model state, index 0 = 12-hour instance, 1 = 24-hour instance
   int m_secs[2];
   int m_presc[2];
   bit m_dp[2];
   bit m_err[2];

   always #5 clk = ~clk;

   rtc_bcd_counter #(.MODE24(1'b0), .DIV(DIVT)) u12 (
      .clk(clk), .rst(rst), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
      .hh_t(h_t[0]), .hh_o(h_o[0]), .mm_t(m_t[0]), .mm_o(m_o[0]), .ss_t(s_t[0]), .ss_o(s_o[0]),
      .pm(pmo[0]), .day_pulse(dpo[0]), .ld_err(ero[0]));

   rtc_bcd_counter #(.MODE24(1'b1), .DIV(DIVT)) u24 (
      .clk(clk), .rst(rst), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
      .hh_t(h_t[1]), .hh_o(h_o[1]), .mm_t(m_t[1]), .mm_o(m_o[1]), .ss_t(s_t[1]), .ss_o(s_o[1]),
      .pm(pmo[1]), .day_pulse(dpo[1]), .ld_err(ero[1]));

   function automatic logic [19:0] mk(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   // Displayed digits for a seconds-of-day value; 12-hour shows hour 0 and 12 as 12
   function automatic logic [19:0] disp(input int md, input int secs);
      int h24;
      int h;
      h24 = secs / 3600;
      h = (md == 1) ? h24 : (((h24 % 12) == 0) ? 12 : (h24 % 12));
      return mk(h, (secs / 60) % 60, secs % 60);
   endfunction

   // Seconds-of-day encoded by a load word, or -1 when the load is illegal
   function automatic int load_val(input int md, input logic [19:0] t, input bit p);
      int ht, ho, mt, mo, st, so, hrs;
      ht = int'(t[19:18]); ho = int'(t[17:14]); mt = int'(t[13:11]);
      mo = int'(t[10:7]);  st = int'(t[6:4]);   so = int'(t[3:0]);
      if (ho > 9 || mo > 9 || so > 9 || mt > 5 || st > 5) return -1;
      hrs = ht * 10 + ho;
      if (md == 1) begin
         if (hrs > 23) return -1;
      end else begin
         if (hrs < 1 || hrs > 12) return -1;
         hrs = (hrs % 12) + (p ? 12 : 0);
      end
      return hrs * 3600 + (mt * 10 + mo) * 60 + st * 10 + so;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] tod(input int md);
      return {h_t[md], h_o[md], m_t[md], m_o[md], s_t[md], s_o[md]};
   endfunction

   task automatic model_step(input bit r, input bit e, input bit l,
                             input logic [19:0] t, input bit p);
      for (int md = 0; md < 2; md++) begin
         int lv;
         bit tick;
         if (r) begin
            m_secs[md] = 0; m_presc[md] = 0; m_dp[md] = 0; m_err[md] = 0;
         end else begin
            lv = l ? load_val(md, t, p) : -1;
            tick = e && (m_presc[md] == DIVT - 1);
            m_dp[md] = 0;
            m_err[md] = l && (lv < 0);
            if (lv >= 0) begin
               m_secs[md] = lv;
               m_presc[md] = 0;
            end else begin
               if (e) m_presc[md] = (m_presc[md] + 1) % DIVT;
               if (tick) begin
                  m_secs[md] = (m_secs[md] + 1) % DAY;
                  m_dp[md] = (m_secs[md] == 0);
               end
            end
         end
      end
   endtask

   task automatic chk_model();
      for (int md = 0; md < 2; md++) begin
         string sfx;
         sfx = (md == 1) ? "24" : "12";
         chk({"time", sfx}, 32'(tod(md)), 32'(disp(md, m_secs[md])));
         chk({"pm", sfx}, 32'(pmo[md]), 32'(m_secs[md] >= 43200));
         chk({"day", sfx}, 32'(dpo[md]), 32'(m_dp[md]));
         chk({"err", sfx}, 32'(ero[md]), 32'(m_err[md]));
      end
   endtask

   task automatic step(input bit r, input bit e, input bit l,
                       input logic [19:0] t, input bit p);
      rst = r; en = e; load = l; ld_time = t; ld_pm = p;
      @(posedge clk);
      model_step(r, e, l, t, p);
      #1;
      chk_model();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 20'd0, 1'b0);
   endtask

   initial begin
      for (int md = 0; md < 2; md++) begin
         m_secs[md] = 0; m_presc[md] = 0; m_dp[md] = 0; m_err[md] = 0;
      end

      // Reset state
      step(1, 0, 0, 20'd0, 0);
      step(1, 0, 0, 20'd0, 0);
      chk("rst24", 32'(tod(1)), 32'(mk(0, 0, 0)));
      chk("rst12", 32'(tod(0)), 32'(mk(12, 0, 0)));
      chk("rstpm", 32'({pmo[0], pmo[1]}), 32'd0);

      // Eight enabled cycles give two seconds
      run(4);
      chk("first_tick", 32'(s_o[1]), 32'd1);
      run(4);
      chk("two_sec24", 32'(tod(1)), 32'(mk(0, 0, 2)));
      chk("two_sec12", 32'(tod(0)), 32'(mk(12, 0, 2)));

      // 24-hour day rollover (same word is an illegal 12-hour load)
      step(0, 0, 1, mk(23, 59, 59), 0);
      chk("ld2359_pm", 32'(pmo[1]), 32'd1);
      chk("ld2359_err12", 32'(ero[0]), 32'd1);
      run(4);
      chk("roll24", 32'(tod(1)), 32'(mk(0, 0, 0)));
      chk("roll24_day", 32'(dpo[1]), 32'd1);
      chk("roll24_pm", 32'(pmo[1]), 32'd0);
      step(0, 0, 0, 20'd0, 0);
      chk("roll24_day_off", 32'(dpo[1]), 32'd0);

      // 12-hour transitions
      step(0, 0, 1, mk(11, 59, 59), 0);
      run(4);
      chk("noon", 32'(tod(0)), 32'(mk(12, 0, 0)));
      chk("noon_pm", 32'(pmo[0]), 32'd1);
      chk("noon_day", 32'(dpo[0]), 32'd0);
      step(0, 0, 1, mk(12, 59, 59), 1);
      run(4);
      chk("one_pm", 32'(tod(0)), 32'(mk(1, 0, 0)));
      chk("one_pm_pm", 32'(pmo[0]), 32'd1);
      step(0, 0, 1, mk(11, 59, 59), 1);
      run(4);
      chk("midnight", 32'(tod(0)), 32'(mk(12, 0, 0)));
      chk("midnight_pm", 32'(pmo[0]), 32'd0);
      chk("midnight_day", 32'(dpo[0]), 32'd1);

      // Illegal loads leave time untouched
      step(0, 0, 1, mk(1, 2, 3), 0);
      step(0, 0, 1, mk(24, 0, 0), 0);
      chk("bad24_err", 32'({ero[0], ero[1]}), 32'd3);
      chk("bad24_keep", 32'(tod(1)), 32'(mk(1, 2, 3)));
      step(0, 0, 1, mk(0, 15, 0), 0);
      chk("bad12_err", 32'({ero[0], ero[1]}), 32'd2);
      chk("bad12_keep", 32'(tod(0)), 32'(mk(1, 2, 3)));
      step(0, 0, 1, mk(10, 0, 0) | 20'h0000A, 0);
      chk("badbcd_err", 32'({ero[0], ero[1]}), 32'd3);
      chk("badbcd_keep", 32'(tod(1)), 32'(mk(0, 15, 0)));

      // Load coincident with a second tick
      step(0, 0, 1, mk(5, 6, 6), 0);
      run(3);
      step(0, 1, 1, mk(5, 6, 7), 0);
      chk("coinc_ld", 32'(tod(1)), 32'(mk(5, 6, 7)));
      run(3);
      chk("coinc_hold", 32'(tod(1)), 32'(mk(5, 6, 7)));
      run(1);
      chk("coinc_next", 32'(tod(1)), 32'(mk(5, 6, 8)));

      // Enable gaps, then reset with a partial prescaler count
      run(2);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 20'd0, 0);
      chk("en_hold", 32'(tod(1)), 32'(mk(5, 6, 8)));
      step(1, 1, 1, mk(9, 9, 9), 0);
      chk("rst_mid24", 32'(tod(1)), 32'(mk(0, 0, 0)));
      chk("rst_mid12", 32'(tod(0)), 32'(mk(12, 0, 0)));
      run(3);
      chk("rst_nopartial", 32'(s_o[1]), 32'd0);
      run(1);
      chk("rst_firsttick", 32'(s_o[1]), 32'd1);

      // Randomized traffic biased towards field boundaries
      for (int i = 0; i < 3000; i++) begin
         bit r, e, l, p;
         logic [19:0] t;
         int s;
         r = ($urandom % 150) == 0;
         e = ($urandom % 4) != 0;
         l = ($urandom % 25) == 0;
         p = 1'($urandom % 2);
         case ($urandom % 4)
            0: t = 20'($urandom);
            1: begin
               s = ($urandom % 2) ? 43200 : DAY;
               s = s - 1 - int'($urandom % 3);
               t = mk(s / 3600, (s / 60) % 60, s % 60);
            end
            2: t = mk(int'($urandom % 24), 59, 56 + int'($urandom % 4));
            default: t = mk(int'($urandom % 13), int'($urandom % 60), int'($urandom % 60));
         endcase
         step(r, e, l, t, p);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
